// File: rtl/dualis_pkg.sv
// Shared definitions for the multi-cycle sequencer: RV32 opcode values,
// sequencer states, opcode classes and the opcode classifier.
package dualis_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        ERR
    } seq_state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_LUI,
        CL_AUIPC,
        CL_ILLEGAL
    } op_class_t;

    // Map a raw opcode field onto the class the sequencer steers by.
    function automatic op_class_t classify(input logic [6:0] op);
        op_class_t cls;
        case (op)
            OP_R:      cls = CL_R;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = CL_BRANCH;
            OP_JAL:    cls = CL_JAL;
            OP_LUI:    cls = CL_LUI;
            OP_AUIPC:  cls = CL_AUIPC;
            default:   cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Bus-timeout watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the LIMIT-th consecutive wait would be spent.
module seq_watchdog #(
    parameter int unsigned LIMIT = 15,
    parameter int unsigned TMR_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(LIMIT - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Clear dominates; otherwise count every enabled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clearing event (memory completion) in the same cycle suppresses expiry.
    assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 control sequencer: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB, owns the memory handshake and a bus watchdog.
// Optional feature: define SEQ_PERF_CNT_EN to add the retired_cnt output.
module multicycle_sequencer
    import dualis_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMR_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       alusrc,
    output logic       branch,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       busy,
    output logic       fault
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    seq_state_t state_q, state_d;
    op_class_t  class_q, class_d;
    logic       retire;
    logic       waiting;
    logic       wd_clr;
    logic       wd_expired;

    // The watchdog only runs while a memory access is outstanding.
    assign waiting = (state_q == FETCH) || (state_q == MEM);
    assign wd_clr  = !waiting || mem_ready;

    seq_watchdog #(
        .LIMIT (MEM_TIMEOUT),
        .TMR_W (TMR_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (waiting),
        .expired (wd_expired)
    );

    // State and latched opcode class registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            class_q <= CL_R;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    // Next-state logic; run is consulted only in IDLE and at retire.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (mem_ready)       state_d = DECODE;
                else if (wd_expired) state_d = ERR;
            end
            DECODE: begin
                class_d = classify(opcode);
                state_d = (class_d == CL_ILLEGAL) ? ERR : EXEC;
            end
            EXEC: begin
                case (class_q)
                    CL_BRANCH:         retire  = 1'b1;
                    CL_LOAD, CL_STORE: state_d = MEM;
                    default:           state_d = WB;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    if (class_q == CL_LOAD) state_d = WB;
                    else                    retire  = 1'b1;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            WB:      retire  = 1'b1;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
        if (retire) state_d = run ? FETCH : IDLE;
    end

    // Moore strobes from state and class; only ir_write/pc_write see live inputs.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alusrc     = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        busy       = 1'b0;
        fault      = 1'b0;
        case (state_q)
            FETCH: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            DECODE: busy = 1'b1;
            EXEC: begin
                busy   = 1'b1;
                alusrc = (class_q != CL_R) && (class_q != CL_BRANCH);
                if (class_q == CL_BRANCH) begin
                    branch   = 1'b1;
                    pc_write = zero;
                end else if (class_q == CL_JAL) begin
                    branch   = 1'b1;
                    pc_write = 1'b1;
                end
            end
            MEM: begin
                busy      = 1'b1;
                mem_read  = (class_q == CL_LOAD);
                mem_write = (class_q == CL_STORE);
            end
            WB: begin
                busy       = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = (class_q == CL_LOAD);
                pc_write   = (class_q != CL_JAL);
            end
            ERR:     fault = 1'b1;
            default: busy  = 1'b0;
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt_q;
    logic [31:0] retired_cnt_d;

    // Count retiring instructions; wraps naturally at 2^32.
    always_comb begin
        retired_cnt_d = retired_cnt_q + {31'd0, retire};
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: opcode table, directed
// multi-cycle corner cases and a randomized run against a procedural model.
module tb_multicycle_sequencer;

    localparam int TMO = 15;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    // Expected-output bit masks, ordered {ir,pc,rw,alu,br,mr,mw,m2r,busy,fault}.
    localparam logic [9:0] IR  = 10'h200;
    localparam logic [9:0] PC  = 10'h100;
    localparam logic [9:0] RW  = 10'h080;
    localparam logic [9:0] ALU = 10'h040;
    localparam logic [9:0] BR  = 10'h020;
    localparam logic [9:0] MR  = 10'h010;
    localparam logic [9:0] MW  = 10'h008;
    localparam logic [9:0] M2R = 10'h004;
    localparam logic [9:0] B   = 10'h002;
    localparam logic [9:0] FLT = 10'h001;
    localparam logic [9:0] NONE = 10'h000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_write, pc_write, reg_write, alusrc, branch;
    logic       mem_read, mem_write, mem_to_reg, busy, fault;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int model_retired = 0;

    wire [9:0] outs = {ir_write, pc_write, reg_write, alusrc, branch,
                       mem_read, mem_write, mem_to_reg, busy, fault};

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .MEM_TIMEOUT (TMO),
        .TMR_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alusrc     (alusrc),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .busy       (busy),
        .fault      (fault)
`ifdef SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    typedef struct {
        logic [6:0]  op;
        int          cycles;
        logic [31:0] counts;   // nibbles: ir,pc,rw,alu,br,mr,mw,m2r
        logic        flt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, sample outputs 1ns later.
    task automatic cyc(input logic r, input logic [6:0] op, input logic z, input logic mr,
                       input logic [9:0] exp, input string name);
        @(negedge clk);
        run = r; opcode = op; zero = z; mem_ready = mr;
        #1;
        check(name, {22'd0, outs}, {22'd0, exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset", {22'd0, outs}, 32'd0);
        model_retired = 0;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op == T_R || op == T_LOAD || op == T_STORE || op == T_BRANCH ||
               op == T_JAL || op == T_LUI || op == T_AUIPC;
    endfunction

    // Memory wait: strobe held until ready, or TMO cycles without ready.
    task automatic wait_mem(input logic [6:0] op, input logic [9:0] strobe, input bit fetch,
                            output bit ok, output logic last_run);
        bit   stall;
        logic mr;
        logic r;
        stall = ($urandom_range(0, 15) == 0);
        ok = 1'b0;
        last_run = 1'b0;
        for (int w = 0; w < TMO; w++) begin
            mr = stall ? 1'b0 : ($urandom_range(0, 2) == 0);
            r  = rb();
            cyc(r, op, rb(), mr, strobe | B | ((fetch && mr) ? IR : NONE), "rnd_mem");
            if (mr) begin
                ok = 1'b1;
                last_run = r;
                break;
            end
        end
    endtask

    // Fault is sticky and ignores run; then recover through reset.
    task automatic err_tail(input logic [6:0] op);
        cyc(rb(), op, rb(), rb(), FLT, "rnd_err");
        cyc(rb(), op, rb(), rb(), FLT, "rnd_err_sticky");
`ifdef SEQ_PERF_CNT_EN
        check("rnd_retired_err", retired_cnt, model_retired);
`endif
        do_reset();
    endtask

    initial begin
        vec_t       vecs[10];
        logic [6:0] legal_ops[7];
        int         cnt[8];
        int         n;
        logic [31:0] word;
        bit         idle;
        bit         ok;
        logic       r;
        logic       z;
        logic [6:0] op;

        vecs[0] = '{T_R,      4, 32'h1110_0100, 1'b0};
        vecs[1] = '{T_LOAD,   5, 32'h1111_0201, 1'b0};
        vecs[2] = '{T_STORE,  4, 32'h1001_0110, 1'b0};
        vecs[3] = '{T_BRANCH, 3, 32'h1100_1100, 1'b0};
        vecs[4] = '{T_JAL,    4, 32'h1111_1100, 1'b0};
        vecs[5] = '{T_LUI,    4, 32'h1111_0100, 1'b0};
        vecs[6] = '{T_AUIPC,  4, 32'h1111_0100, 1'b0};
        vecs[7] = '{7'h7F,    2, 32'h1000_0100, 1'b1};
        vecs[8] = '{7'h00,    2, 32'h1000_0100, 1'b1};
        vecs[9] = '{7'h31,    2, 32'h1000_0100, 1'b1};
        legal_ops = '{T_R, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_LUI, T_AUIPC};

        // Opcode table: one instruction from IDLE with mem_ready and zero tied high.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            cyc(1'b1, vecs[v].op, 1'b1, 1'b1, NONE, "tbl_idle");
            for (int i = 0; i < 8; i++) cnt[i] = 0;
            n = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                run = 1'b0; opcode = vecs[v].op; zero = 1'b1; mem_ready = 1'b1;
                #1;
                if (!busy) break;
                n++;
                for (int i = 0; i < 8; i++) cnt[i] += int'(outs[9-i]);
            end
            word = 32'd0;
            for (int i = 0; i < 8; i++) word[(7-i)*4 +: 4] = 4'(cnt[i]);
            check("tbl_cycles", n, vecs[v].cycles);
            check("tbl_strobes", word, vecs[v].counts);
            check("tbl_fault", {31'd0, fault}, {31'd0, vecs[v].flt});
            $display("table op=%b cycles=%0d strobes=%h fault=%b", vecs[v].op, n, word, fault);
        end

        // R-type twice back to back; run drops during the second EXEC.
        do_reset();
        cyc(1, T_R, 0, 1, NONE,        "r_idle");
        cyc(1, T_R, 0, 1, IR | MR | B, "r_fetch");
        cyc(1, T_R, 0, 1, B,           "r_decode");
        cyc(1, T_R, 0, 1, B,           "r_exec");
        cyc(1, T_R, 0, 1, RW | PC | B, "r_wb");
        cyc(1, T_R, 0, 1, IR | MR | B, "r_fetch2");
        cyc(1, T_R, 0, 1, B,           "r_decode2");
        cyc(0, T_R, 0, 1, B,           "r_exec_run0");
        cyc(0, T_R, 0, 1, RW | PC | B, "r_wb_run0");
        cyc(0, T_R, 0, 1, NONE,        "r_idle_after");
        $display("seq r-type with run drop done");

        // LOAD with three wait cycles in MEM.
        do_reset();
        cyc(1, T_LOAD, 0, 1, NONE,        "ld_idle");
        cyc(0, T_LOAD, 0, 1, IR | MR | B, "ld_fetch");
        cyc(0, T_LOAD, 0, 0, B,           "ld_decode");
        cyc(0, T_LOAD, 0, 0, ALU | B,     "ld_exec");
        for (int i = 0; i < 3; i++) cyc(0, T_LOAD, 0, 0, MR | B, "ld_mem_wait");
        cyc(0, T_LOAD, 0, 1, MR | B,             "ld_mem_done");
        cyc(0, T_LOAD, 0, 0, RW | PC | M2R | B,  "ld_wb");
        cyc(0, T_LOAD, 0, 0, NONE,               "ld_idle_after");
        $display("seq load with mem stall done");

        // BRANCH taken then not taken.
        do_reset();
        cyc(1, T_BRANCH, 0, 1, NONE,          "br_idle");
        cyc(1, T_BRANCH, 0, 1, IR | MR | B,   "br_fetch");
        cyc(1, T_BRANCH, 0, 1, B,             "br_decode");
        cyc(1, T_BRANCH, 1, 1, BR | PC | B,   "br_exec_taken");
        cyc(1, T_BRANCH, 0, 1, IR | MR | B,   "br_fetch2");
        cyc(1, T_BRANCH, 0, 1, B,             "br_decode2");
        cyc(0, T_BRANCH, 0, 1, BR | B,        "br_exec_not_taken");
        cyc(0, T_BRANCH, 1, 1, NONE,          "br_idle_after");
        $display("seq branch taken/not-taken done");

        // Illegal opcode: sticky fault, run ignored, reset recovers.
        do_reset();
        cyc(1, 7'h7F, 0, 1, NONE,        "ill_idle");
        cyc(1, 7'h7F, 0, 1, IR | MR | B, "ill_fetch");
        cyc(1, 7'h7F, 0, 1, B,           "ill_decode");
        cyc(1, 7'h7F, 0, 1, FLT,         "ill_err");
        cyc(0, 7'h7F, 0, 1, FLT,         "ill_err_run0");
        cyc(1, 7'h7F, 0, 1, FLT,         "ill_err_run1");
        do_reset();
        cyc(0, 7'h7F, 0, 1, NONE,        "ill_after_reset");
        $display("seq illegal opcode done");

        // STORE with no mem_ready: exactly TMO write cycles, then fault.
        do_reset();
        cyc(1, T_STORE, 0, 1, NONE,        "st_idle");
        cyc(0, T_STORE, 0, 1, IR | MR | B, "st_fetch");
        cyc(0, T_STORE, 0, 0, B,           "st_decode");
        cyc(0, T_STORE, 0, 0, ALU | B,     "st_exec");
        for (int i = 0; i < TMO; i++) cyc(0, T_STORE, 0, 0, MW | B, "st_mem_wait");
        cyc(0, T_STORE, 0, 0, FLT, "st_timeout");
        // Same again with mem_ready arriving on the last allowed cycle.
        do_reset();
        cyc(1, T_STORE, 0, 1, NONE,        "st2_idle");
        cyc(0, T_STORE, 0, 1, IR | MR | B, "st2_fetch");
        cyc(0, T_STORE, 0, 0, B,           "st2_decode");
        cyc(0, T_STORE, 0, 0, ALU | B,     "st2_exec");
        for (int i = 0; i < TMO - 1; i++) cyc(0, T_STORE, 0, 0, MW | B, "st2_mem_wait");
        cyc(0, T_STORE, 0, 1, MW | B, "st2_mem_last");
        cyc(0, T_STORE, 0, 0, NONE,   "st2_no_fault");
        $display("seq store timeout boundary done");

        // Reset asserted in MEM: takes effect at the next edge only.
        do_reset();
        cyc(1, T_STORE, 0, 1, NONE,        "rm_idle");
        cyc(0, T_STORE, 0, 1, IR | MR | B, "rm_fetch");
        cyc(0, T_STORE, 0, 0, B,           "rm_decode");
        cyc(0, T_STORE, 0, 0, ALU | B,     "rm_exec");
        cyc(0, T_STORE, 0, 0, MW | B,      "rm_mem");
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        check("rm_pre_edge", {22'd0, outs}, {22'd0, MW | B});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rm_post_edge", {22'd0, outs}, 32'd0);
        $display("seq reset during mem done");

        // Randomized instruction stream against the procedural model.
        do_reset();
        idle = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 11) == 0) op = 7'($urandom);
            else op = legal_ops[$urandom_range(0, 6)];
            if (idle) begin
                for (int w = 0; w < 8; w++) begin
                    r = (w == 7) ? 1'b1 : rb();
                    cyc(r, op, rb(), rb(), NONE, "rnd_idle");
                    if (r) break;
                end
            end
            wait_mem(op, MR, 1'b1, ok, r);
            if (!ok) begin
                $display("rnd #%0d op=%b fetch timeout", k, op);
                err_tail(op); idle = 1'b1; continue;
            end
            cyc(rb(), op, rb(), rb(), B, "rnd_decode");
            if (!is_legal(op)) begin
                $display("rnd #%0d op=%b illegal", k, op);
                err_tail(op); idle = 1'b1; continue;
            end
            z = rb();
            r = rb();
            ok = 1'b1;
            case (op)
                T_BRANCH: cyc(r, op, z, rb(), BR | B | (z ? PC : NONE), "rnd_br_exec");
                T_JAL: begin
                    cyc(rb(), op, z, rb(), BR | PC | ALU | B, "rnd_jal_exec");
                    cyc(r, op, z, rb(), RW | B, "rnd_jal_wb");
                end
                T_R: begin
                    cyc(rb(), op, z, rb(), B, "rnd_r_exec");
                    cyc(r, op, z, rb(), RW | PC | B, "rnd_r_wb");
                end
                T_LOAD: begin
                    cyc(rb(), op, z, rb(), ALU | B, "rnd_ld_exec");
                    wait_mem(op, MR, 1'b0, ok, r);
                    r = rb();
                    if (ok) cyc(r, op, z, rb(), RW | PC | M2R | B, "rnd_ld_wb");
                end
                T_STORE: begin
                    cyc(rb(), op, z, rb(), ALU | B, "rnd_st_exec");
                    wait_mem(op, MW, 1'b0, ok, r);
                end
                default: begin
                    cyc(rb(), op, z, rb(), ALU | B, "rnd_u_exec");
                    cyc(r, op, z, rb(), RW | PC | B, "rnd_u_wb");
                end
            endcase
            if (!ok) begin
                $display("rnd #%0d op=%b mem timeout", k, op);
                err_tail(op); idle = 1'b1; continue;
            end
            model_retired++;
            idle = !r;
            $display("rnd #%0d op=%b retired run=%b", k, op, r);
        end
`ifdef SEQ_PERF_CNT_EN
        @(negedge clk);
        #1;
        check("rnd_retired_end", retired_cnt, model_retired);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
